// File: rtl/le_cell.sv
// le_cell: less-than-or-equal comparator cell.
// Drives a purely combinational out = (a <= b). It also has a one-cycle
// registered stage with lt/eq flags, a valid strobe, and a saturating hit counter.
module le_cell #(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out,
    input  logic             in_valid,
    input  logic             clr,
    output logic             out_q,
    output logic             lt_q,
    output logic             eq_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] le_count
);

    // Inverting the sign bit maps two's-complement order onto unsigned order,
    // so one unsigned comparator covers both modes.
    localparam logic [WIDTH-1:0] SIGN_FLIP = (SIGNED != 0) ? (WIDTH'(1) << (WIDTH - 1)) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [WIDTH-1:0] a_key;
    logic [WIDTH-1:0] b_key;
    logic             lt;
    logic             eq;

    assign a_key = a ^ SIGN_FLIP;
    assign b_key = b ^ SIGN_FLIP;
    assign lt    = (a_key < b_key);
    assign eq    = (a == b);
    assign out   = lt | eq;

    // Compare flags load on accepted samples and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
            lt_q  <= 1'b0;
            eq_q  <= 1'b0;
        end else if (in_valid) begin
            out_q <= out;
            lt_q  <= lt;
            eq_q  <= eq;
        end
    end

    // The valid strobe is a one-cycle delayed copy of in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    // The hit counter saturates. A clear wins over an increment in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            le_count <= '0;
        end else if (clr) begin
            le_count <= '0;
        end else if (in_valid && out && (le_count != CNT_MAX)) begin
            le_count <= le_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_le_cell.sv
// Testbench for le_cell.
// Three instances share one input set: unsigned, signed, and unsigned with a 2-bit counter.
module tb_le_cell;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       clr;

    logic       out_v      [3];
    logic       out_q_v    [3];
    logic       lt_q_v     [3];
    logic       eq_q_v     [3];
    logic       out_valid_v[3];
    logic [7:0] cnt_v      [3];

    logic [7:0] cnt_uns;
    logic [7:0] cnt_sgn;
    logic [1:0] cnt_sat;

    int checks   = 0;
    int failures = 0;

    // Model state for each instance.
    int m_sgn   [3] = '{0, 1, 0};
    int m_max   [3] = '{255, 255, 3};
    int m_out_q [3];
    int m_lt    [3];
    int m_eq    [3];
    int m_valid [3];
    int m_cnt   [3];

    le_cell #(.WIDTH(4), .SIGNED(0), .CNT_W(8)) u_uns (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out_v[0]),
        .in_valid(in_valid), .clr(clr), .out_q(out_q_v[0]), .lt_q(lt_q_v[0]),
        .eq_q(eq_q_v[0]), .out_valid(out_valid_v[0]), .le_count(cnt_uns)
    );

    le_cell #(.WIDTH(4), .SIGNED(1), .CNT_W(8)) u_sgn (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out_v[1]),
        .in_valid(in_valid), .clr(clr), .out_q(out_q_v[1]), .lt_q(lt_q_v[1]),
        .eq_q(eq_q_v[1]), .out_valid(out_valid_v[1]), .le_count(cnt_sgn)
    );

    le_cell #(.WIDTH(4), .SIGNED(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .out(out_v[2]),
        .in_valid(in_valid), .clr(clr), .out_q(out_q_v[2]), .lt_q(lt_q_v[2]),
        .eq_q(eq_q_v[2]), .out_valid(out_valid_v[2]), .le_count(cnt_sat)
    );

    assign cnt_v[0] = cnt_uns;
    assign cnt_v[1] = cnt_sgn;
    assign cnt_v[2] = {6'b0, cnt_sat};

    // The clock can be halted so that the combinational sweep runs with no edges.
    always #5 if (clk_en) clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       exp_uns;
        logic       exp_sgn;
    } vec_t;

    vec_t vecs[10];

    function automatic int val(logic [3:0] x, int sgn);
        return (sgn != 0 && x[3]) ? int'(x) - 16 : int'(x);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_out_q[i] = 0; m_lt[i] = 0; m_eq[i] = 0; m_valid[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic model_edge(logic [3:0] ta, logic [3:0] tb_, logic iv, logic cl);
        for (int i = 0; i < 3; i++) begin
            int va = val(ta, m_sgn[i]);
            int vb = val(tb_, m_sgn[i]);
            if (iv) begin
                m_out_q[i] = (va <= vb) ? 1 : 0;
                m_lt[i]    = (va < vb) ? 1 : 0;
                m_eq[i]    = (va == vb) ? 1 : 0;
            end
            m_valid[i] = iv ? 1 : 0;
            if (cl) m_cnt[i] = 0;
            else if (iv && va <= vb && m_cnt[i] < m_max[i]) m_cnt[i] = m_cnt[i] + 1;
        end
    endtask

    task automatic compare_all(string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s out[%0d]", tag, i), 32'(out_v[i]),
                  (val(a, m_sgn[i]) <= val(b, m_sgn[i])) ? 1 : 0);
            check($sformatf("%s out_q[%0d]", tag, i), 32'(out_q_v[i]), m_out_q[i]);
            check($sformatf("%s lt_q[%0d]", tag, i), 32'(lt_q_v[i]), m_lt[i]);
            check($sformatf("%s eq_q[%0d]", tag, i), 32'(eq_q_v[i]), m_eq[i]);
            check($sformatf("%s out_valid[%0d]", tag, i), 32'(out_valid_v[i]), m_valid[i]);
            check($sformatf("%s le_count[%0d]", tag, i), 32'(cnt_v[i]), m_cnt[i]);
        end
    endtask

    // Apply inputs, clock once, then update the model and compare everything.
    task automatic step(logic [3:0] ta, logic [3:0] tb_, logic iv, logic cl, string tag);
        a = ta; b = tb_; in_valid = iv; clr = cl;
        @(posedge clk);
        #1;
        model_edge(ta, tb_, iv, cl);
        compare_all(tag);
    endtask

    initial begin
        vecs[0] = '{4'd0,  4'd0,  1'b1, 1'b1};
        vecs[1] = '{4'd2,  4'd0,  1'b0, 1'b0};
        vecs[2] = '{4'd3,  4'd1,  1'b0, 1'b0};
        vecs[3] = '{4'd4,  4'd6,  1'b1, 1'b1};
        vecs[4] = '{4'd3,  4'd2,  1'b0, 1'b0};
        vecs[5] = '{4'd15, 4'd15, 1'b1, 1'b1};
        vecs[6] = '{4'd15, 4'd0,  1'b0, 1'b1};
        vecs[7] = '{4'd0,  4'd15, 1'b1, 1'b0};
        vecs[8] = '{4'd15, 4'd1,  1'b0, 1'b1};
        vecs[9] = '{4'd7,  4'd8,  1'b1, 1'b0};

        clk = 0; clk_en = 0; rst_n = 0;
        a = 0; b = 0; in_valid = 0; clr = 0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset out_q[%0d]", i), 32'(out_q_v[i]), 0);
            check($sformatf("reset out_valid[%0d]", i), 32'(out_valid_v[i]), 0);
            check($sformatf("reset le_count[%0d]", i), 32'(cnt_v[i]), 0);
        end

        // Combinational sweep: the clock is halted and reset is held.
        for (int i = 0; i < 10; i++) begin
            a = vecs[i].a; b = vecs[i].b;
            #2;
            check($sformatf("comb uns v%0d", i), 32'(out_v[0]), 32'(vecs[i].exp_uns));
            check($sformatf("comb sgn v%0d", i), 32'(out_v[1]), 32'(vecs[i].exp_sgn));
            check($sformatf("comb sat v%0d", i), 32'(out_v[2]), 32'(vecs[i].exp_uns));
        end

        rst_n = 1;
        #1;
        clk_en = 1;

        // Signed sample -1 vs 1.
        step(4'd15, 4'd1, 1'b1, 1'b0, "signed");
        check("signed lt_q", 32'(lt_q_v[1]), 1);
        check("signed out_q", 32'(out_q_v[1]), 1);
        check("unsigned out_q 15v1", 32'(out_q_v[0]), 0);

        // Back-to-back samples, then one idle cycle.
        step(4'd2, 4'd2, 1'b1, 1'b0, "b2b1");
        check("b2b1 out_q", 32'(out_q_v[0]), 1);
        check("b2b1 eq_q", 32'(eq_q_v[0]), 1);
        check("b2b1 lt_q", 32'(lt_q_v[0]), 0);
        check("b2b1 out_valid", 32'(out_valid_v[0]), 1);
        step(4'd5, 4'd3, 1'b1, 1'b0, "b2b2");
        check("b2b2 out_q", 32'(out_q_v[0]), 0);
        check("b2b2 eq_q", 32'(eq_q_v[0]), 0);
        check("b2b2 lt_q", 32'(lt_q_v[0]), 0);
        step(4'd0, 4'd0, 1'b0, 1'b0, "idle");
        check("idle out_valid", 32'(out_valid_v[0]), 0);
        check("idle out_q hold", 32'(out_q_v[0]), 0);

        // Counter saturation on the 2-bit instance, then clear beats increment.
        step(4'd0, 4'd0, 1'b0, 1'b1, "pre-clr");
        check("pre-clr sat", 32'(cnt_v[2]), 0);
        for (int i = 0; i < 5; i++) begin
            step(4'd1, 4'd2, 1'b1, 1'b0, "sat");
            check($sformatf("sat count %0d", i), 32'(cnt_v[2]), (i < 3) ? i + 1 : 3);
        end
        step(4'd1, 4'd2, 1'b1, 1'b1, "clr-prio");
        check("clr-prio count", 32'(cnt_v[2]), 0);
        check("clr-prio out_q", 32'(out_q_v[2]), 1);

        // Asynchronous reset between edges.
        step(4'd3, 4'd3, 1'b1, 1'b0, "pre-rst");
        #2;
        rst_n = 0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("async out_q[%0d]", i), 32'(out_q_v[i]), 0);
            check($sformatf("async eq_q[%0d]", i), 32'(eq_q_v[i]), 0);
            check($sformatf("async out_valid[%0d]", i), 32'(out_valid_v[i]), 0);
            check($sformatf("async le_count[%0d]", i), 32'(cnt_v[i]), 0);
        end
        a = 4'd1; b = 4'd4;
        #1;
        check("async out follows", 32'(out_v[0]), 1);
        @(negedge clk);
        rst_n = 1;
        step(4'd6, 4'd6, 1'b1, 1'b0, "post-rst");
        check("post-rst eq_q", 32'(eq_q_v[0]), 1);
        check("post-rst count", 32'(cnt_v[0]), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
